// File: rtl/bpf_pkg.sv
// rtl/bpf_pkg.sv - shared state, phase and status definitions for the BPF step sequencer
package bpf_pkg;

    typedef logic [1:0] state_t;
    typedef logic [2:0] phase_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int NUM_PHASES = 5;

    localparam phase_t PH_FETCH  = 3'd0;
    localparam phase_t PH_DECODE = 3'd1;
    localparam phase_t PH_EXEC   = 3'd2;
    localparam phase_t PH_MEM    = 3'd3;
    localparam phase_t PH_WB     = 3'd4;

    typedef struct packed {
        logic running;
        logic paused;
        logic done;
        logic timeout;
    } status_t;

    // Unused phase codes decode to no strobe so the one-hot invariant cannot break.
    function automatic logic [NUM_PHASES-1:0] phaseOneHot(input phase_t ph);
        logic [NUM_PHASES-1:0] oh;
        oh = '0;
        case (ph)
            PH_FETCH:  oh[0] = 1'b1;
            PH_DECODE: oh[1] = 1'b1;
            PH_EXEC:   oh[2] = 1'b1;
            PH_MEM:    oh[3] = 1'b1;
            PH_WB:     oh[4] = 1'b1;
            default:   oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/bpf_step_ctrl_if.sv
// rtl/bpf_step_ctrl_if.sv - host/debug control inputs and datapath phase strobes
interface bpf_step_ctrl_if #(
    parameter int CNT_W = 32
);

    logic             iSTART;
    logic             iSTEP_MODE;
    logic             iSTEP_REQ;
    logic             iHALT_REQ;
    logic             iMEM_WAIT;
    logic             iRET;

    logic             oSTEP1;
    logic             oSTEP2;
    logic             oSTEP3;
    logic             oSTEP4;
    logic             oSTEP5;
    logic             oRUNNING;
    logic             oPAUSED;
    logic             oDONE;
    logic             oTIMEOUT;
    logic [CNT_W-1:0] oINSN_CNT;

    modport master (
        output iSTART, iSTEP_MODE, iSTEP_REQ, iHALT_REQ, iMEM_WAIT, iRET,
        input  oSTEP1, oSTEP2, oSTEP3, oSTEP4, oSTEP5,
        input  oRUNNING, oPAUSED, oDONE, oTIMEOUT, oINSN_CNT
    );

    modport slave (
        input  iSTART, iSTEP_MODE, iSTEP_REQ, iHALT_REQ, iMEM_WAIT, iRET,
        output oSTEP1, oSTEP2, oSTEP3, oSTEP4, oSTEP5,
        output oRUNNING, oPAUSED, oDONE, oTIMEOUT, oINSN_CNT
    );

endinterface

// File: rtl/bpf_stall_wdog.sv
// rtl/bpf_stall_wdog.sv - consecutive memory-stall counter raising a hit on the WDOG_MAX-th stall
module bpf_stall_wdog #(
    parameter int                WDOG_W   = 16,
    parameter logic [WDOG_W-1:0] WDOG_MAX = 16'hFFFF
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iStall,
    input  logic iClear,
    output logic oHit
);

    localparam logic [WDOG_W-1:0] HIT_AT = WDOG_MAX - WDOG_W'(1);

    logic [WDOG_W-1:0] stallCnt;

    // stallCnt holds the number of earlier stalls in the current run, so the
    // WDOG_MAX-th consecutive stalled cycle is the one that sees HIT_AT.
    assign oHit = iStall && (stallCnt == HIT_AT);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            stallCnt <= '0;
        end else if (!iStall || iClear || oHit) begin
            stallCnt <= '0;
        end else begin
            stallCnt <= stallCnt + WDOG_W'(1);
        end
    end

endmodule

// File: rtl/bpf_step_ctrl.sv
// rtl/bpf_step_ctrl.sv - 5-phase instruction sequencer with run/halt/single-step and stall watchdog
module bpf_step_ctrl #(
    parameter int                CNT_W    = 32,
    parameter int                WDOG_W   = 16,
    parameter logic [WDOG_W-1:0] WDOG_MAX = 16'hFFFF
) (
    input  logic             iCLK,
    input  logic             iRST,
    bpf_step_ctrl_if.slave   bus
);

    import bpf_pkg::*;

    state_t                  state;
    state_t                  stateNext;
    phase_t                  phase;
    phase_t                  phaseNext;
    logic                    retLatch;
    logic                    retNext;
    logic                    stepPend;
    logic                    pendNext;
    logic [CNT_W-1:0]        insnCnt;
    logic [CNT_W-1:0]        cntNext;
    logic                    timeoutNext;
    logic [NUM_PHASES-1:0]   stepReg;
    status_t                 statusReg;

    logic                    stall;
    logic                    startFresh;
    logic                    wdogHit;

    assign stall = (state == ST_RUN) && bus.iMEM_WAIT &&
                   ((phase == PH_FETCH) || (phase == PH_MEM));
    assign startFresh = ((state == ST_IDLE) || (state == ST_DONE)) && bus.iSTART;

    bpf_stall_wdog #(
        .WDOG_W   (WDOG_W),
        .WDOG_MAX (WDOG_MAX)
    ) uWdog (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iStall (stall),
        .iClear (startFresh),
        .oHit   (wdogHit)
    );

    always_comb begin
        stateNext   = state;
        phaseNext   = phase;
        retNext     = retLatch;
        pendNext    = stepPend;
        cntNext     = insnCnt;
        timeoutNext = statusReg.timeout;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.iSTART) begin
                    stateNext   = ST_RUN;
                    phaseNext   = PH_FETCH;
                    retNext     = 1'b0;
                    pendNext    = 1'b0;
                    cntNext     = '0;
                    timeoutNext = 1'b0;
                end
            end

            ST_PAUSE: begin
                // A step request beats a plain resume and forces a pause at the next boundary.
                if (bus.iSTEP_REQ) begin
                    stateNext = ST_RUN;
                    phaseNext = PH_FETCH;
                    pendNext  = 1'b1;
                end else if (bus.iSTART) begin
                    stateNext = ST_RUN;
                    phaseNext = PH_FETCH;
                    pendNext  = 1'b0;
                end
            end

            ST_RUN: begin
                if ((phase == PH_EXEC) && bus.iRET) begin
                    retNext = 1'b1;
                end

                if (wdogHit) begin
                    stateNext   = ST_DONE;
                    phaseNext   = PH_FETCH;
                    timeoutNext = 1'b1;
                end else if (!stall) begin
                    if (phase == PH_WB) begin
                        if (insnCnt != '1) begin
                            cntNext = insnCnt + CNT_W'(1);
                        end
                        pendNext  = 1'b0;
                        phaseNext = PH_FETCH;
                        if (retLatch) begin
                            stateNext = ST_DONE;
                        end else if (bus.iHALT_REQ || bus.iSTEP_MODE || stepPend) begin
                            stateNext = ST_PAUSE;
                        end
                    end else begin
                        phaseNext = phase + 3'd1;
                    end
                end
            end

            default: begin
                stateNext = ST_IDLE;
                phaseNext = PH_FETCH;
            end
        endcase
    end

    // Strobes and status are flopped from the next-state values so they line up with state.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state     <= ST_IDLE;
            phase     <= PH_FETCH;
            retLatch  <= 1'b0;
            stepPend  <= 1'b0;
            insnCnt   <= '0;
            stepReg   <= '0;
            statusReg <= '0;
        end else begin
            state     <= stateNext;
            phase     <= phaseNext;
            retLatch  <= retNext;
            stepPend  <= pendNext;
            insnCnt   <= cntNext;
            stepReg   <= (stateNext == ST_RUN) ? phaseOneHot(phaseNext) : '0;
            statusReg <= '{running: (stateNext == ST_RUN),
                           paused:  (stateNext == ST_PAUSE),
                           done:    (stateNext == ST_DONE),
                           timeout: timeoutNext};
        end
    end

    assign bus.oSTEP1    = stepReg[0];
    assign bus.oSTEP2    = stepReg[1];
    assign bus.oSTEP3    = stepReg[2];
    assign bus.oSTEP4    = stepReg[3];
    assign bus.oSTEP5    = stepReg[4];
    assign bus.oRUNNING  = statusReg.running;
    assign bus.oPAUSED   = statusReg.paused;
    assign bus.oDONE     = statusReg.done;
    assign bus.oTIMEOUT  = statusReg.timeout;
    assign bus.oINSN_CNT = insnCnt;

endmodule

// File: tb/tb_bpf_step_ctrl.sv
// tb/tb_bpf_step_ctrl.sv - self-checking bench for bpf_step_ctrl
module tb_bpf_step_ctrl;

    localparam logic [5:0] I_NONE  = 6'b000000;
    localparam logic [5:0] I_START = 6'b100000;
    localparam logic [5:0] I_SMODE = 6'b010000;
    localparam logic [5:0] I_SREQ  = 6'b001000;
    localparam logic [5:0] I_HALT  = 6'b000100;
    localparam logic [5:0] I_WAIT  = 6'b000010;
    localparam logic [5:0] I_RET   = 6'b000001;

    localparam logic [4:0] Z0 = 5'b00000;
    localparam logic [4:0] S1 = 5'b00001;
    localparam logic [4:0] S2 = 5'b00010;
    localparam logic [4:0] S3 = 5'b00100;
    localparam logic [4:0] S4 = 5'b01000;
    localparam logic [4:0] S5 = 5'b10000;

    localparam logic [3:0] ST_NONE = 4'b0000;
    localparam logic [3:0] ST_RUN  = 4'b1000;
    localparam logic [3:0] ST_PSE  = 4'b0100;
    localparam logic [3:0] ST_DN   = 4'b0010;
    localparam logic [3:0] ST_TMO  = 4'b0001;

    // inp = {start, stepMode, stepReq, halt, memWait, ret}, applied before an edge;
    // step/st/cnt are the outputs required just after that edge.
    typedef struct {
        logic [5:0] inp;
        logic [4:0] step;
        logic [3:0] st;
        int         cnt;
    } row_t;

    logic iCLK = 1'b0;
    logic iRST;
    int   checks = 0;
    int   errors = 0;
    row_t tbl[$];
    row_t q[$];

    always #5 iCLK = ~iCLK;

    bpf_step_ctrl_if #(.CNT_W(32)) bus ();
    bpf_step_ctrl_if #(.CNT_W(2))  bus2 ();

    assign bus2.iSTART     = bus.iSTART;
    assign bus2.iSTEP_MODE = bus.iSTEP_MODE;
    assign bus2.iSTEP_REQ  = bus.iSTEP_REQ;
    assign bus2.iHALT_REQ  = bus.iHALT_REQ;
    assign bus2.iMEM_WAIT  = bus.iMEM_WAIT;
    assign bus2.iRET       = bus.iRET;

    bpf_step_ctrl #(.CNT_W(32), .WDOG_W(16), .WDOG_MAX(16'd8)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    bpf_step_ctrl #(.CNT_W(2), .WDOG_W(16), .WDOG_MAX(16'd8)) dutSat (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus2)
    );

    function automatic row_t mk(logic [5:0] inp, logic [4:0] step, logic [3:0] st, int cnt);
        row_t r;
        r.inp  = inp;
        r.step = step;
        r.st   = st;
        r.cnt  = cnt;
        return r;
    endfunction

    function automatic logic [5:0] rnd(logic [5:0] mask);
        return 6'($urandom) & mask;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [5:0] inp);
        {bus.iSTART, bus.iSTEP_MODE, bus.iSTEP_REQ, bus.iHALT_REQ, bus.iMEM_WAIT, bus.iRET} = inp;
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic expectOut(string name, logic [4:0] step, logic [3:0] st, int cnt);
        int satc;
        satc = (cnt > 3) ? 3 : cnt;
        check({name, " step"}, 64'({bus.oSTEP5, bus.oSTEP4, bus.oSTEP3, bus.oSTEP2, bus.oSTEP1}), 64'(step));
        check({name, " status"}, 64'({bus.oRUNNING, bus.oPAUSED, bus.oDONE, bus.oTIMEOUT}), 64'(st));
        check({name, " cnt"}, 64'(bus.oINSN_CNT), 64'(cnt));
        check({name, " sat"},
              64'({bus2.oSTEP5, bus2.oSTEP4, bus2.oSTEP3, bus2.oSTEP2, bus2.oSTEP1,
                   bus2.oRUNNING, bus2.oPAUSED, bus2.oDONE, bus2.oTIMEOUT, bus2.oINSN_CNT}),
              64'({step, st, 2'(satc)}));
    endtask

    task automatic applyRow(string name, row_t r);
        drive(r.inp);
        tick();
        expectOut(name, r.step, r.st, r.cnt);
    endtask

    // Random program: builds the expected cycle trace from a per-instruction plan
    // (fetch/mem wait lengths, pause reasons, how each pause is left).
    task automatic buildRandomRun(int n);
        logic pend;
        logic [5:0] ign;
        q.delete();
        pend = 1'b0;
        ign  = I_START | I_SREQ | I_HALT | I_SMODE;
        q.push_back(mk(I_START, S1, ST_RUN, 0));
        for (int i = 0; i < n; i++) begin
            int   w1;
            int   w4;
            logic last;
            logic pauseWhy;
            logic pauseHere;
            w1       = $urandom_range(0, 5);
            w4       = $urandom_range(0, 5);
            last     = (i == n - 1);
            pauseWhy = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < w1; k++) q.push_back(mk(rnd(ign | I_RET) | I_WAIT, S1, ST_RUN, i));
            q.push_back(mk(rnd(ign | I_RET), S2, ST_RUN, i));
            q.push_back(mk(rnd(ign | I_RET | I_WAIT), S3, ST_RUN, i));
            q.push_back(mk(rnd(ign | I_WAIT) | (last ? I_RET : I_NONE), S4, ST_RUN, i));
            for (int k = 0; k < w4; k++) q.push_back(mk(rnd(ign | I_RET) | I_WAIT, S4, ST_RUN, i));
            q.push_back(mk(rnd(ign | I_RET), S5, ST_RUN, i));
            pauseHere = pauseWhy || pend;
            ign = pauseWhy ? (($urandom_range(0, 1) == 0) ? I_HALT : I_SMODE) : I_NONE;
            ign = ign | rnd(I_START | I_SREQ | I_RET | I_WAIT);
            if (last) begin
                q.push_back(mk(ign, Z0, ST_DN, i + 1));
            end else if (pauseHere) begin
                int   plen;
                logic viaStep;
                q.push_back(mk(ign, Z0, ST_PSE, i + 1));
                plen = $urandom_range(0, 2);
                for (int k = 0; k < plen; k++) q.push_back(mk(rnd(I_HALT | I_WAIT | I_RET | I_SMODE), Z0, ST_PSE, i + 1));
                viaStep = ($urandom_range(0, 1) == 0);
                q.push_back(mk((viaStep ? (I_SREQ | rnd(I_START)) : I_START) | rnd(I_HALT | I_WAIT | I_RET),
                               S1, ST_RUN, i + 1));
                pend = viaStep;
            end else begin
                q.push_back(mk(ign, S1, ST_RUN, i + 1));
                pend = 1'b0;
            end
            ign = I_START | I_SREQ | I_HALT | I_SMODE;
        end
        q.push_back(mk(rnd(I_HALT | I_WAIT | I_RET | I_SREQ), Z0, ST_DN, n));
    endtask

    initial begin
        // Free run of three instructions ending on RET, then a stalled instruction.
        tbl.push_back(mk(I_START, S1, ST_RUN, 0));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk(I_NONE, S2, ST_RUN, i));
            tbl.push_back(mk(I_NONE, S3, ST_RUN, i));
            tbl.push_back(mk((i == 2) ? I_RET : I_NONE, S4, ST_RUN, i));
            tbl.push_back(mk(I_NONE, S5, ST_RUN, i));
            tbl.push_back((i == 2) ? mk(I_NONE, Z0, ST_DN, 3) : mk(I_NONE, S1, ST_RUN, i + 1));
        end
        tbl.push_back(mk(I_NONE, Z0, ST_DN, 3));
        tbl.push_back(mk(I_START, S1, ST_RUN, 0));
        tbl.push_back(mk(I_NONE, S2, ST_RUN, 0));
        tbl.push_back(mk(I_WAIT, S3, ST_RUN, 0));
        tbl.push_back(mk(I_NONE, S4, ST_RUN, 0));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(I_WAIT, S4, ST_RUN, 0));
        tbl.push_back(mk(I_NONE, S5, ST_RUN, 0));
        tbl.push_back(mk(I_NONE, S1, ST_RUN, 1));
        tbl.push_back(mk(I_NONE, S2, ST_RUN, 1));
        tbl.push_back(mk(I_NONE, S3, ST_RUN, 1));
        tbl.push_back(mk(I_RET, S4, ST_RUN, 1));
        tbl.push_back(mk(I_NONE, S5, ST_RUN, 1));
        tbl.push_back(mk(I_NONE, Z0, ST_DN, 2));

        iRST = 1'b1;
        drive(I_NONE);
        repeat (2) @(posedge iCLK);
        #1;
        expectOut("reset", Z0, ST_NONE, 0);
        #3 iRST = 1'b0;
        tick();
        expectOut("idle", Z0, ST_NONE, 0);

        foreach (tbl[i]) applyRow($sformatf("tbl%0d", i), tbl[i]);

        // Single-step: mode-driven pause, then step requests (one beating a start).
        drive(I_SMODE | I_START);
        tick();
        expectOut("ss start", S1, ST_RUN, 0);
        drive(I_SMODE);
        repeat (4) tick();
        expectOut("ss s5", S5, ST_RUN, 0);
        tick();
        expectOut("ss pause1", Z0, ST_PSE, 1);
        tick();
        expectOut("ss hold", Z0, ST_PSE, 1);
        for (int k = 0; k < 2; k++) begin
            drive((k == 0) ? (I_SMODE | I_SREQ) : (I_SREQ | I_START));
            tick();
            expectOut($sformatf("ss req%0d", k), S1, ST_RUN, 1 + k);
            drive((k == 0) ? I_SMODE : I_NONE);
            repeat (4) tick();
            tick();
            expectOut($sformatf("ss pause%0d", k + 2), Z0, ST_PSE, 2 + k);
        end
        drive(I_START);
        tick();
        expectOut("free resume", S1, ST_RUN, 3);
        drive(I_NONE);
        repeat (5) tick();
        expectOut("free next", S1, ST_RUN, 4);

        // Halt raised mid-instruction completes the instruction first.
        tick();
        expectOut("halt s2", S2, ST_RUN, 4);
        drive(I_HALT);
        tick();
        expectOut("halt s3", S3, ST_RUN, 4);
        tick();
        expectOut("halt s4", S4, ST_RUN, 4);
        tick();
        expectOut("halt s5", S5, ST_RUN, 4);
        tick();
        expectOut("halt pause", Z0, ST_PSE, 5);
        drive(I_START);
        tick();
        expectOut("halt resume", S1, ST_RUN, 5);
        drive(I_NONE);
        tick();
        tick();
        expectOut("pre arst s3", S3, ST_RUN, 5);

        // Asynchronous reset between edges.
        #3 iRST = 1'b1;
        #1;
        expectOut("arst", Z0, ST_NONE, 0);
        #3 iRST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            expectOut($sformatf("post arst%0d", k), Z0, ST_NONE, 0);
        end

        // Watchdog: 7 stalls never time out and a free cycle clears the count.
        drive(I_START);
        tick();
        expectOut("wd start", S1, ST_RUN, 0);
        drive(I_WAIT);
        repeat (7) tick();
        expectOut("wd s1 7", S1, ST_RUN, 0);
        drive(I_NONE);
        tick();
        expectOut("wd s2", S2, ST_RUN, 0);
        repeat (2) tick();
        drive(I_WAIT);
        repeat (7) tick();
        expectOut("wd s4 7", S4, ST_RUN, 0);
        drive(I_NONE);
        tick();
        expectOut("wd s5", S5, ST_RUN, 0);
        tick();
        expectOut("wd next", S1, ST_RUN, 1);
        drive(I_WAIT);
        repeat (7) tick();
        expectOut("wd held", S1, ST_RUN, 1);
        tick();
        expectOut("wd timeout", Z0, ST_DN | ST_TMO, 1);
        drive(I_NONE);
        tick();
        expectOut("wd sticky", Z0, ST_DN | ST_TMO, 1);
        drive(I_START);
        tick();
        expectOut("wd restart", S1, ST_RUN, 0);
        drive(I_NONE);

        #2 iRST = 1'b1;
        #4 iRST = 1'b0;
        tick();
        expectOut("rnd idle", Z0, ST_NONE, 0);

        for (int run = 0; run < 4; run++) begin
            buildRandomRun(6);
            foreach (q[j]) applyRow($sformatf("rnd%0d.%0d", run, j), q[j]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
